// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus the decode-side handshake.
// The master modport is the fetch unit; the slave modport is the memory/decode side.
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_exc;

  modport master (
    output imem_req, imem_addr, id_valid, id_inst, id_pc, id_pc4, id_exc,
    input  imem_rvalid, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_inst, id_pc, id_pc4, id_exc,
    output imem_rvalid, imem_rdata, id_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch feeding a 2-entry decode buffer.
// Optional feature: define INST_FETCH_ALIGN_CHECK_EN to turn a misaligned PC into a
// NOP entry flagged with id_exc instead of a memory read.
module inst_fetch (
  input  logic         clk,
  input  logic         clr,
  input  logic [31:0]  current_pc,
  input  logic         flush,
  output logic         pc_adv,
  inst_fetch_if.master bus
);

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e      state_q, state_d;
  logic [1:0]  count_q;
  logic        wr_ptr_q, rd_ptr_q;
  logic        imem_req_q;
  logic [31:0] imem_addr_q;
  logic [31:0] req_pc_q;
  logic [31:0] inst_q [2];
  logic [31:0] pc_q   [2];

  logic        issue, push, pop, buf_valid;
  logic [31:0] push_inst;

`ifdef INST_FETCH_ALIGN_CHECK_EN
  logic        exc_pend_q;
  logic        exc_q [2];
  logic        push_exc;
`endif

  assign buf_valid = (count_q != 2'd0);
  assign pop       = buf_valid && bus.id_ready;

  // Next state, push decision and pc_adv; a flush forces pc_adv and suppresses any push.
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    push      = 1'b0;
    push_inst = bus.imem_rdata;
    pc_adv    = flush;
`ifdef INST_FETCH_ALIGN_CHECK_EN
    push_exc  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (!flush && count_q != 2'd2) begin
          issue   = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
`ifdef INST_FETCH_ALIGN_CHECK_EN
        if (exc_pend_q) begin
          // No read was issued; deliver a trapping NOP in place of the response.
          push      = !flush;
          push_inst = '0;
          push_exc  = 1'b1;
          pc_adv    = 1'b1;
          state_d   = StIdle;
        end else
`endif
        if (bus.imem_rvalid) begin
          push    = !flush;
          pc_adv  = 1'b1;
          state_d = StIdle;
        end else if (flush) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        // The stale response is swallowed whatever flush does this cycle.
        if (bus.imem_rvalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state, buffer pointers/count and the registered memory request.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= StIdle;
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      req_pc_q    <= '0;
`ifdef INST_FETCH_ALIGN_CHECK_EN
      exc_pend_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      imem_req_q <= 1'b0;
`ifdef INST_FETCH_ALIGN_CHECK_EN
      exc_pend_q <= 1'b0;
`endif
      if (flush) begin
        count_q  <= 2'd0;
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
        count_q <= count_q + 2'(push) - 2'(pop);
      end
      if (issue) begin
        req_pc_q <= current_pc;
`ifdef INST_FETCH_ALIGN_CHECK_EN
        if (current_pc[1:0] != 2'b00) begin
          exc_pend_q <= 1'b1;
        end else begin
`else
        begin
`endif
          imem_req_q  <= 1'b1;
          imem_addr_q <= {current_pc[31:2], 2'b00};
        end
      end
    end
  end

  // Buffer storage; outputs are masked when empty so the payload needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_ptr_q] <= push_inst;
      pc_q[wr_ptr_q]   <= req_pc_q;
`ifdef INST_FETCH_ALIGN_CHECK_EN
      exc_q[wr_ptr_q]  <= push_exc;
`endif
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = imem_addr_q;
  assign bus.id_valid  = buf_valid;
  assign bus.id_inst   = buf_valid ? inst_q[rd_ptr_q] : '0;
  assign bus.id_pc     = buf_valid ? pc_q[rd_ptr_q] : '0;
  assign bus.id_pc4    = bus.id_pc + 32'd4;
`ifdef INST_FETCH_ALIGN_CHECK_EN
  assign bus.id_exc    = buf_valid ? exc_q[rd_ptr_q] : 1'b0;
`else
  assign bus.id_exc    = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized traffic checked against a
// transaction-level model (queue of decode entries, outstanding/discard flags).
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        clr;
  logic        flush;
  logic [31:0] current_pc;
  logic        pc_adv;

  inst_fetch_if bus ();

  inst_fetch dut (
    .clk        (clk),
    .clr        (clr),
    .current_pc (current_pc),
    .flush      (flush),
    .pc_adv     (pc_adv),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        exc;
  } ent_t;

  // Reference model state
  ent_t        q[$];
  bit          m_out, m_disc, m_exc, m_req_now;
  logic [31:0] m_addr, m_pc;

  // Memory model
  bit          mem_busy;
  int          mem_cnt;
  int          lat = 1;
  bit          use_fixed;
  logic [31:0] fixed_data;
  bit          spurious;

  // Per-cycle samples and expectations
  logic        a_req, a_rvalid, a_pc_adv, a_valid, a_exc;
  logic [31:0] a_addr, a_inst, a_pc, a_pc4, a_rdata;
  logic        e_req, e_pc_adv, e_valid, e_exc;
  logic [31:0] e_addr, e_inst, e_pc, e_pc4;

  int n_tests = 0;
  int n_fail  = 0;

  // One clock cycle: drive memory, sample DUT, compute expectations, advance the model.
  task automatic step();
    ent_t ent;
    int   sz;
    bit   busy_before, push;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = use_fixed ? fixed_data : $urandom();
        mem_busy        = 1'b0;
      end
    end else if (spurious) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = $urandom();
    end
    #1;
    a_req    = bus.imem_req;    a_addr  = bus.imem_addr;
    a_rvalid = bus.imem_rvalid; a_rdata = bus.imem_rdata;
    a_valid  = bus.id_valid;    a_inst  = bus.id_inst;
    a_pc     = bus.id_pc;       a_pc4   = bus.id_pc4;
    a_exc    = bus.id_exc;      a_pc_adv = pc_adv;
    e_req    = m_req_now;
    e_addr   = m_addr;
    e_valid  = (q.size() != 0);
    e_inst   = e_valid ? q[0].inst : 32'h0;
    e_pc     = e_valid ? q[0].pc   : 32'h0;
    e_exc    = e_valid ? q[0].exc  : 1'b0;
    e_pc4    = e_pc + 32'd4;
    e_pc_adv = flush || (m_out && !m_disc && a_rvalid) || m_exc;
    @(posedge clk);
    if (!clr) begin
      q.delete();
      m_out = 0; m_disc = 0; m_exc = 0; m_req_now = 0;
      m_addr = '0; m_pc = '0;
      mem_busy = 0; mem_cnt = 0;
    end else begin
      sz          = q.size();
      busy_before = m_out || m_exc;
      push        = !flush && ((m_out && !m_disc && a_rvalid) || m_exc);
      if (m_exc) ent = '{inst: 32'h0, pc: m_pc, exc: 1'b1};
      else       ent = '{inst: a_rdata, pc: m_pc, exc: 1'b0};
      if (flush) q.delete();
      else begin
        if (sz > 0 && bus.id_ready) void'(q.pop_front());
        if (push) q.push_back(ent);
      end
      m_exc = 0;
      if (m_out) begin
        if (a_rvalid) begin
          m_out = 0; m_disc = 0;
        end else if (flush) begin
          m_disc = 1;
        end
      end
      m_req_now = 0;
      if (!busy_before && sz < 2 && !flush) begin
        m_pc = current_pc;
`ifdef INST_FETCH_ALIGN_CHECK_EN
        if (current_pc[1:0] != 2'b00) m_exc = 1;
        else begin
`else
        begin
`endif
          m_out     = 1;
          m_req_now = 1;
          m_addr    = {current_pc[31:2], 2'b00};
        end
      end
      if (a_req) begin
        mem_busy = 1;
        mem_cnt  = lat;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr = 1'b0; flush = 1'b0; bus.id_ready = 1'b0;
    spurious = 0; use_fixed = 0; lat = 1;
    step();
    clr = 1'b1;
  endtask

  task automatic test_reset();
    clr = 1'b0; flush = 1'b0; bus.id_ready = 1'b0; current_pc = 32'h0040_0000;
    step();
    step();
    n_tests++;
    if ({bus.id_valid, bus.id_inst, bus.id_pc, bus.id_pc4, bus.id_exc, bus.imem_req,
         bus.imem_addr, pc_adv} !== {1'b0, 32'h0, 32'h0, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got v=%b inst=%h pc=%h pc4=%h exc=%b req=%b addr=%h adv=%b, required 0/0/0/4/0/0/0/0",
               bus.id_valid, bus.id_inst, bus.id_pc, bus.id_pc4, bus.id_exc, bus.imem_req,
               bus.imem_addr, pc_adv);
    end
    clr = 1'b1;
    step();
    n_tests++;
    if ({a_req, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h0040_0000}) begin
      n_fail++;
      $display("FAIL first_req: got prev=%b req=%b addr=%h, required 0 1 00400000",
               a_req, bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_single_fetch();
    do_reset();
    current_pc = 32'h0040_0000; use_fixed = 1; fixed_data = 32'h2008_0005; bus.id_ready = 1'b1;
    step();
    step();
    step();
    n_tests++;
    if ({a_rvalid, a_pc_adv} !== 2'b11) begin
      n_fail++;
      $display("FAIL single_pc_adv: got rvalid=%b pc_adv=%b, required 1 1", a_rvalid, a_pc_adv);
    end
    n_tests++;
    if ({bus.id_valid, bus.id_inst, bus.id_pc, bus.id_pc4} !==
        {1'b1, 32'h2008_0005, 32'h0040_0000, 32'h0040_0004}) begin
      n_fail++;
      $display("FAIL single_entry: got v=%b inst=%h pc=%h pc4=%h, required 1 20080005 00400000 00400004",
               bus.id_valid, bus.id_inst, bus.id_pc, bus.id_pc4);
    end
  endtask

  task automatic test_backpressure();
    int          reqs = 0;
    int          pushes = 0;
    logic [31:0] data [2];
    do_reset();
    current_pc = 32'h0000_1000;
    for (int i = 0; i < 12; i++) begin
      step();
      if (a_req) reqs++;
      if (a_pc_adv) begin
        if (pushes < 2) data[pushes] = a_rdata;
        pushes++;
        current_pc = 32'h0000_1000 + 32'(pushes * 4);
      end
    end
    n_tests++;
    if (reqs != 2 || pushes != 2) begin
      n_fail++;
      $display("FAIL bp_counts: got reqs=%0d pushes=%0d, required 2 2", reqs, pushes);
    end
    n_tests++;
    if ({bus.id_valid, bus.id_pc, bus.id_inst} !== {1'b1, 32'h0000_1000, data[0]}) begin
      n_fail++;
      $display("FAIL bp_head: got v=%b pc=%h inst=%h, required 1 00001000 %h",
               bus.id_valid, bus.id_pc, bus.id_inst, data[0]);
    end
    // Stray response while idle must be ignored.
    spurious = 1;
    step();
    spurious = 0;
    n_tests++;
    if ({a_pc_adv, bus.imem_req, bus.id_pc} !== {1'b0, 1'b0, 32'h0000_1000}) begin
      n_fail++;
      $display("FAIL idle_rvalid: got adv=%b req=%b pc=%h, required 0 0 00001000",
               a_pc_adv, bus.imem_req, bus.id_pc);
    end
    bus.id_ready = 1'b1;
    step();
    bus.id_ready = 1'b0;
    n_tests++;
    if ({bus.id_pc, bus.id_inst} !== {32'h0000_1004, data[1]}) begin
      n_fail++;
      $display("FAIL bp_order: got pc=%h inst=%h, required 00001004 %h",
               bus.id_pc, bus.id_inst, data[1]);
    end
    step();
    n_tests++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0000_1008}) begin
      n_fail++;
      $display("FAIL bp_third_req: got req=%b addr=%h, required 1 00001008",
               bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_flush();
    bit seen = 0;
    do_reset();
    current_pc = 32'h0040_0000; use_fixed = 1; fixed_data = 32'hDEAD_BEEF; lat = 3;
    step();
    step();
    flush = 1'b1; current_pc = 32'h0040_0100;
    step();
    flush = 1'b0;
    n_tests++;
    if (a_pc_adv !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pc_adv: got %b, required 1", a_pc_adv);
    end
    step();
    step();
    n_tests++;
    if ({a_rvalid, a_pc_adv, bus.id_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL flush_drop: got rvalid=%b adv=%b id_valid=%b, required 1 0 0",
               a_rvalid, a_pc_adv, bus.id_valid);
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.imem_req === 1'b1) begin
        seen = 1;
        break;
      end
      step();
    end
    n_tests++;
    if (!seen || bus.imem_addr !== 32'h0040_0100) begin
      n_fail++;
      $display("FAIL flush_redirect: got seen=%b addr=%h, required 1 00400100", seen, bus.imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    current_pc = 32'hFFFF_FFFC;
    step();
    step();
    step();
    n_tests++;
    if ({bus.id_valid, bus.id_pc, bus.id_pc4} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
      n_fail++;
      $display("FAIL wrap: got v=%b pc=%h pc4=%h, required 1 fffffffc 00000000",
               bus.id_valid, bus.id_pc, bus.id_pc4);
    end
  endtask

  task automatic test_align();
    do_reset();
    current_pc = 32'h0040_0002;
    step();
`ifdef INST_FETCH_ALIGN_CHECK_EN
    n_tests++;
    if (bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL align_no_req: got req=%b, required 0", bus.imem_req);
    end
    step();
    n_tests++;
    if ({a_pc_adv, bus.id_valid, bus.id_inst, bus.id_exc} !== {1'b1, 1'b1, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL align_exc: got adv=%b v=%b inst=%h exc=%b, required 1 1 0 1",
               a_pc_adv, bus.id_valid, bus.id_inst, bus.id_exc);
    end
`else
    n_tests++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0040_0000}) begin
      n_fail++;
      $display("FAIL align_addr: got req=%b addr=%h, required 1 00400000",
               bus.imem_req, bus.imem_addr);
    end
    step();
    step();
    n_tests++;
    if ({bus.id_valid, bus.id_exc} !== 2'b10) begin
      n_fail++;
      $display("FAIL align_noexc: got v=%b exc=%b, required 1 0", bus.id_valid, bus.id_exc);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] pc;
    do_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      clr          = ($urandom_range(0, 49) != 0);
      flush        = clr && ($urandom_range(0, 11) == 0);
      bus.id_ready = 1'($urandom_range(0, 1));
      lat          = $urandom_range(1, 3);
      pc           = $urandom();
      if ($urandom_range(0, 7) != 0) pc = pc & 32'hFFFF_FFFC;
      current_pc   = pc;
      step();
      n_tests++;
      if ({a_req, (e_req ? a_addr : 32'h0), a_valid, a_inst, a_pc, a_pc4, a_exc, a_pc_adv} !==
          {e_req, (e_req ? e_addr : 32'h0), e_valid, e_inst, e_pc, e_pc4, e_exc, e_pc_adv}) begin
        n_fail++;
        $display("FAIL random cyc %0d: got req=%b addr=%h v=%b inst=%h pc=%h pc4=%h exc=%b adv=%b, required req=%b addr=%h v=%b inst=%h pc=%h pc4=%h exc=%b adv=%b",
                 cyc, a_req, a_addr, a_valid, a_inst, a_pc, a_pc4, a_exc, a_pc_adv,
                 e_req, e_addr, e_valid, e_inst, e_pc, e_pc4, e_exc, e_pc_adv);
      end
    end
    clr   = 1'b1;
    flush = 1'b0;
  endtask

  initial begin
    clr = 1'b0; flush = 1'b0; current_pc = '0;
    bus.id_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    @(negedge clk);
    test_reset();
    test_single_fetch();
    test_backpressure();
    test_flush();
    test_wrap();
    test_align();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port clr, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL have port current_pc, input, 32, PC presented by the pc stage.
REQ-004 SHALL have port pc_adv, output, 1, pc stage may load its next PC at this edge; else holds current_pc.
REQ-005 SHALL have port imem_req, output, 1, one-cycle instruction-memory read strobe.
REQ-006 SHALL have port imem_addr, output, 32, word-aligned read address, valid while imem_req=1.
REQ-007 SHALL have port imem_rvalid, input, 1, read data valid; never earlier than the cycle after imem_req.
REQ-008 SHALL have port imem_rdata, input, 32, instruction word, valid with imem_rvalid.
REQ-009 SHALL have port flush, input, 1, redirect from branch/jump resolution.
REQ-010 SHALL have port id_ready, input, 1, decode stage accepts the head entry.
REQ-011 SHALL have ports id_valid (1), id_inst (32), id_pc (32), id_pc4 (32), id_exc (1), outputs, head entry to decode.

Function
REQ-012 SHALL implement FSM IDLE, WAIT, DROP; at most one memory request outstanding.
REQ-013 IDLE with count<2 and flush=0: next cycle imem_req=1, imem_addr={current_pc[31:2],2'b00}, req_pc latched, state->WAIT.
REQ-014 imem_req SHALL be high exactly one cycle per request; no request in WAIT or DROP.
REQ-015 WAIT with imem_rvalid=1 and flush=0: push {imem_rdata, req_pc} into buffer, pc_adv=1 that cycle, state->IDLE.
REQ-016 pc_adv SHALL be combinational, 1 only on a REQ-015 push or while flush=1, else 0.
REQ-017 Buffer SHALL be a 2-entry FIFO; id_valid=(count!=0); id_inst/id_pc/id_exc from head entry, 0 when empty.
REQ-018 Pop SHALL occur when id_valid&id_ready; simultaneous push and pop SHALL keep count unchanged and preserve order.
REQ-019 Buffer SHALL never overflow: requests issued only when count<2, so a response always has a free slot.
REQ-020 id_pc4 SHALL equal id_pc+4 modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-021 flush=1 SHALL clear the buffer at that edge (id_valid=0 next cycle), override any pop/push, and block new requests that cycle.
REQ-022 flush in WAIT without imem_rvalid SHALL go to DROP; flush in WAIT with imem_rvalid SHALL discard the data and go to IDLE.
REQ-023 DROP SHALL discard the next imem_rvalid data, no push, pc_adv=0 (unless flush), then ->IDLE; a further flush in DROP stays in DROP.
REQ-024 imem_rvalid in IDLE SHALL be ignored.

Reset
REQ-025 clr=0 at an edge SHALL set state IDLE, count 0, imem_req 0, imem_addr 0, req_pc 0; outputs id_valid/id_inst/id_pc/id_exc 0, id_pc4 4, pc_adv 0.
REQ-026 Reset SHALL take priority over flush, push and pop; reset mid-WAIT abandons the request; memory is reset by the same clr.

Configuration
REQ-027 Macro INST_FETCH_ALIGN_CHECK_EN defined: current_pc[1:0]!=0 at issue SHALL push an entry with id_inst=0 (NOP), id_exc=1 without a memory request (push one cycle after issue decision, pc_adv=1 that cycle).
REQ-028 Macro undefined: current_pc[1:0] SHALL be ignored (address forced aligned), id_exc tied 0.

Verification
REQ-029 Reset: clr=0 two cycles, current_pc=0x00400000 -> all outputs at REQ-025 values; first imem_req one cycle after clr=1, imem_addr=0x00400000.
REQ-030 Single fetch: rvalid one cycle after req, rdata=0x20080005, id_ready=1 -> pc_adv pulse that cycle; next cycle id_valid=1, id_inst=0x20080005, id_pc=0x00400000, id_pc4=0x00400004.
REQ-031 Backpressure: id_ready=0, three fetches attempted -> exactly two pushes, count 2, no third imem_req until one pop; order preserved.
REQ-032 Flush: flush asserted in WAIT, rvalid two cycles later with 0xDEADBEEF -> word discarded, id_valid stays 0, next imem_addr = redirected current_pc 0x00400100.
REQ-033 Wrap: current_pc=0xFFFFFFFC fetched -> id_pc=0xFFFFFFFC, id_pc4=0x00000000.
REQ-034 Align check (macro defined): current_pc=0x00400002 -> no imem_req, id_valid=1, id_inst=0, id_exc=1; macro undefined -> imem_addr=0x00400000, id_exc=0.
